// File: rtl/cic_comp_fir_dec2_pkg.sv
// Shared defaults, controller state encoding and a constant log2 helper for
// the CIC compensating decimate-by-2 FIR.
package cic_comp_fir_dec2_pkg;

    localparam int DEF_TAPS       = 32;
    localparam int DEF_IN_WIDTH   = 32;
    localparam int DEF_COEF_WIDTH = 18;
    localparam int DEF_ACC_WIDTH  = 56;
    localparam int DEF_OUT_SHIFT  = 17;
    localparam int DEF_OUT_WIDTH  = 24;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_MAC,
        ST_ROUND
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered data.
// A read of the address being written returns the old contents.
module fir_sdp_ram
    import cic_comp_fir_dec2_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cic_comp_fir_dec2.sv
// Decimate-by-2 compensating FIR behind the CIC: one time-shared MAC over a
// circular sample buffer, host-loadable coefficients, rounded/saturated output.
module cic_comp_fir_dec2
    import cic_comp_fir_dec2_pkg::*;
#(
    parameter int TAPS       = DEF_TAPS,
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int OUT_SHIFT  = DEF_OUT_SHIFT,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    localparam int AW        = clog2(TAPS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_strobe,
    input  logic signed [IN_WIDTH-1:0]   in_data,
    input  logic                         coef_we,
    input  logic [AW-1:0]                coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic                         out_strobe,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         busy,
    output logic                         overrun,
    output state_t                       dbg_state
);

    localparam int CW = AW + 1;
    localparam int PW = IN_WIDTH + COEF_WIDTH;
    localparam logic signed [ACC_WIDTH:0] RND =
        {{(ACC_WIDTH-OUT_SHIFT+1){1'b0}}, 1'b1, {(OUT_SHIFT-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

    state_t                       state;
    logic [CW-1:0]                cnt;
    logic [AW-1:0]                wptr;
    logic [AW-1:0]                base;
    logic                         phase;
    logic                         rd_v;
    logic                         prod_v;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [IN_WIDTH-1:0]   x_rd;
    logic signed [COEF_WIDTH-1:0] c_rd;
    logic                         accept;
    logic                         smp_we;
    logic [AW-1:0]                smp_waddr;
    logic [IN_WIDTH-1:0]          smp_wdata;
    logic [AW-1:0]                smp_raddr;
    logic [AW-1:0]                coef_raddr;
    logic                         coef_wr;
    logic signed [ACC_WIDTH:0]    rsum;
    logic signed [ACC_WIDTH:0]    rshift;
    logic signed [OUT_WIDTH-1:0]  rsat;

    assign dbg_state = state;
    assign accept    = in_strobe && (state != ST_CLEAR);
    assign coef_wr   = coef_we && (state == ST_IDLE);

    // CLEAR owns the sample write port to zero the buffer; otherwise strobes do.
    assign smp_we    = (state == ST_CLEAR) || accept;
    assign smp_waddr = (state == ST_CLEAR) ? cnt[AW-1:0] : wptr;
    assign smp_wdata = (state == ST_CLEAR) ? '0 : in_data;

    // Taps are visited oldest-first (k = TAPS-1 down to 0) so the slot a later
    // strobe overwrites has always been read already.
    assign smp_raddr  = base + AW'(1) + cnt[AW-1:0];
    assign coef_raddr = ~cnt[AW-1:0];

    fir_sdp_ram #(.DEPTH(TAPS), .WIDTH(IN_WIDTH)) u_samples (
        .clk   (clk),
        .we    (smp_we),
        .waddr (smp_waddr),
        .wdata (smp_wdata),
        .raddr (smp_raddr),
        .rdata (x_rd)
    );

    fir_sdp_ram #(.DEPTH(TAPS), .WIDTH(COEF_WIDTH)) u_coefs (
        .clk   (clk),
        .we    (coef_wr),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (coef_raddr),
        .rdata (c_rd)
    );

    always_comb begin
        rsum   = {acc[ACC_WIDTH-1], acc} + RND;
        rshift = rsum >>> OUT_SHIFT;
        if (rshift > OUT_MAX)      rsat = OUT_MAX[OUT_WIDTH-1:0];
        else if (rshift < OUT_MIN) rsat = OUT_MIN[OUT_WIDTH-1:0];
        else                       rsat = rshift[OUT_WIDTH-1:0];
    end

    // MAC pipeline: read (cnt) -> rdata -> prod -> acc; last tap lands in acc
    // on the edge that enters ROUND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_CLEAR;
            busy       <= 1'b1;
            cnt        <= '0;
            wptr       <= '0;
            base       <= '0;
            phase      <= 1'b0;
            overrun    <= 1'b0;
            out_strobe <= 1'b0;
            out_data   <= '0;
            rd_v       <= 1'b0;
            prod_v     <= 1'b0;
            prod       <= '0;
            acc        <= '0;
        end else begin
            out_strobe <= 1'b0;
            rd_v       <= (state == ST_MAC) && (cnt < CW'(TAPS));
            prod_v     <= rd_v;
            prod       <= x_rd * c_rd;
            if (prod_v) acc <= acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

            if (accept) begin
                wptr  <= wptr + AW'(1);
                phase <= ~phase;
                if (phase && state != ST_IDLE) overrun <= 1'b1;
            end

            case (state)
                ST_CLEAR: begin
                    if (cnt == CW'(TAPS - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept && phase) begin
                        state <= ST_MAC;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        base  <= wptr;
                        acc   <= '0;
                    end
                end
                ST_MAC: begin
                    if (cnt == CW'(TAPS + 1)) state <= ST_ROUND;
                    else                      cnt   <= cnt + CW'(1);
                end
                ST_ROUND: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    out_strobe <= 1'b1;
                    out_data   <= rsat;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir_dec2.sv
// Self-checking bench for cic_comp_fir_dec2: directed scenarios plus random
// traffic, scored against a sample-history reference model.
module tb_cic_comp_fir_dec2;
  import cic_comp_fir_dec2_pkg::*;

  localparam int TAPS = 32;
  localparam int OUT_SHIFT = 17;
  localparam int OUT_W = 24;

  logic clk;
  logic reset;
  logic in_strobe;
  logic signed [31:0] in_data;
  logic coef_we;
  logic [4:0] coef_addr;
  logic signed [17:0] coef_data;
  logic out_strobe;
  logic signed [OUT_W-1:0] out_data;
  logic busy;
  logic overrun;
  state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model state
  longint hist[$];
  int coef_m[TAPS];
  int n_acc;
  int clear_end;
  int idle_from;
  logic exp_ovr;
  logic [OUT_W-1:0] exp_q[$];
  int exp_t[$];
  logic signed [OUT_W-1:0] last_out;

  cic_comp_fir_dec2 dut (
    .clk(clk), .reset(reset), .in_strobe(in_strobe), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_strobe(out_strobe), .out_data(out_data), .busy(busy),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_out();
    longint acc;
    int n;
    acc = 0;
    n = hist.size();
    for (int k = 0; k < TAPS; k++)
      if (n - 1 - k >= 0) acc += longint'(coef_m[k]) * hist[n-1-k];
    acc = (acc + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    if (acc > 8388607) acc = 8388607;
    else if (acc < -8388608) acc = -8388608;
    return acc[OUT_W-1:0];
  endfunction

  // a sample sampled at edge e
  function automatic void model_accept(input int e, input int v);
    if (e < clear_end) return;
    hist.push_back(longint'(v));
    n_acc++;
    if (n_acc % 2 == 0) begin
      if (e >= idle_from) begin
        exp_q.push_back(model_out());
        exp_t.push_back(e + TAPS + 3);
        idle_from = e + TAPS + 4;
      end else begin
        exp_ovr = 1'b1;
      end
    end
  endfunction

  // scoreboard
  always @(negedge clk) begin
    logic signed [OUT_W-1:0] exp_v;
    int exp_c;
    if (!reset && out_strobe) begin
      last_out = out_data;
      if (exp_q.size() == 0) begin
        check("unexpected_out", longint'(out_strobe), 0);
      end else begin
        exp_v = exp_q.pop_front();
        exp_c = exp_t.pop_front();
        check("out_data", out_data, exp_v);
        check("latency", cyc, exp_c);
      end
    end
  end

  // driver tasks: each is entered and left just after a falling edge
  task automatic do_reset();
    reset = 1'b1;
    in_strobe = 1'b0;
    coef_we = 1'b0;
    exp_q.delete();
    exp_t.delete();
    hist.delete();
    n_acc = 0;
    exp_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_strobe", out_strobe, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 1);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    clear_end = cyc + TAPS + 1;
    idle_from = cyc + TAPS + 1;
  endtask

  task automatic count_busy(input logic poke);
    int n;
    int v;
    n = 0;
    while (busy && n < 100) begin
      if (poke) begin
        in_strobe = ~in_strobe;
        v = int'($urandom);
        in_data = v;
        if (in_strobe) model_accept(cyc + 1, v);
      end
      @(negedge clk);
      n++;
    end
    in_strobe = 1'b0;
    check("clear_len", n, TAPS);
  endtask

  task automatic send_sample(input int v, input int gap);
    in_strobe = 1'b1;
    in_data = v;
    model_accept(cyc + 1, v);
    @(negedge clk);
    in_strobe = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic write_coef(input int k, input int v);
    coef_we = 1'b1;
    coef_addr = k[4:0];
    coef_data = v[17:0];
    if (cyc + 1 >= idle_from) coef_m[k] = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (TAPS + 6) @(negedge clk);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
  endtask

  task automatic impulse_run();
    send_sample(131072, 40);
    repeat (33) send_sample(0, 40);
    drain();
    check("impulse_tail", last_out, 0);
  endtask

  initial begin
    int v;
    int neg_full;
    reset = 1'b1;
    in_strobe = 1'b0;
    in_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    last_out = '0;
    for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
    @(negedge clk);

    // 1: reset and CLEAR length, strobes ignored during CLEAR
    do_reset();
    count_busy(1'b1);

    // 2: ramp coefficients, impulse response 2,4,...,32 then 0
    load_ramp();
    impulse_run();

    // 3: saturation at both rails
    for (int k = 0; k < TAPS; k++) write_coef(k, 131071);
    repeat (34) send_sample(32'h7FFF_FFFF, 20);
    drain();
    check("sat_pos", last_out, 8388607);
    neg_full = int'(32'h8000_0000);
    repeat (34) send_sample(neg_full, 20);
    drain();
    check("sat_neg", last_out, -8388608);

    // 4: rounding with a single unit tap
    for (int k = 0; k < TAPS; k++) write_coef(k, (k == 0) ? 1 : 0);
    repeat (2) send_sample(65536, 20);
    repeat (2) send_sample(-65536, 20);
    repeat (2) send_sample(65535, 20);
    repeat (2) send_sample(196608, 20);
    drain();
    check("round_last", last_out, 2);

    // 5: over-rate input sets overrun; coefficient write during MAC ignored
    load_ramp();
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 2 ** 20)) - 2 ** 19;
      if (i == 3) begin
        send_sample(v, 3);
        write_coef(0, 5000);
        repeat (6) @(negedge clk);
      end else begin
        send_sample(v, 10);
      end
    end
    drain();
    check("overrun_set", overrun, exp_ovr);
    repeat (2) send_sample(131072, 40);
    drain();

    // 6: reset in the middle of MAC
    send_sample(1000, 20);
    send_sample(2000, 10);
    do_reset();
    count_busy(1'b0);
    impulse_run();
    check("overrun_after_rst", overrun, exp_ovr);

    // 7: random coefficients and samples at or above the minimum spacing
    for (int k = 0; k < TAPS; k++)
      write_coef(k, int'($urandom_range(0, 2 ** 18 - 1)) - 2 ** 17);
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 2 ** 20)) - 2 ** 19;
      send_sample(v, (i < 4) ? 18 : int'($urandom_range(18, 24)));
    end
    drain();
    check("overrun_random", overrun, exp_ovr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
